// File: rtl/fp_normalize.sv
// Post-add normalizer for single-precision results: folds the carry, shifts left one bit per cycle
// until the hidden bit is set, then packs an IEEE-754 word, saturating to infinity or flushing to zero.
module fp_normalize (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_ovf,
  output logic        out_unf
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state, state_nxt;
  logic        sign_p0, sign_nxt;
  logic [24:0] mant_p0, mant_nxt;
  logic [8:0]  exp_p0, exp_nxt, exp_inc;
  logic [31:0] res_p1, res_nxt;
  logic        zero_p1, zero_nxt, ovf_p1, ovf_nxt, unf_p1, unf_nxt;
  logic        vld_p1;

  function automatic logic [31:0] sat_inf(input logic s);
    return {s, 8'hFF, 23'h0};
  endfunction

  function automatic logic [31:0] flush_zero(input logic s);
    return {s, 31'h0};
  endfunction

  // control: state and result-valid are the only reset registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state == DONE) && (state_nxt == DONE);
    end
  end

  // p0: working operand, p1: packed result held through DONE
  always_ff @(posedge clk) begin
    sign_p0 <= sign_nxt;
    mant_p0 <= mant_nxt;
    exp_p0  <= exp_nxt;
    res_p1  <= res_nxt;
    zero_p1 <= zero_nxt;
    ovf_p1  <= ovf_nxt;
    unf_p1  <= unf_nxt;
  end

  always_comb begin
    state_nxt = state;
    sign_nxt  = sign_p0;
    mant_nxt  = mant_p0;
    exp_nxt   = exp_p0;
    res_nxt   = res_p1;
    zero_nxt  = zero_p1;
    ovf_nxt   = ovf_p1;
    unf_nxt   = unf_p1;
    exp_inc   = exp_p0 + 9'd1;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_nxt  = in_sign;
          mant_nxt  = in_mant;
          exp_nxt   = {1'b0, in_exp};
          state_nxt = NORM;
        end
      end
      NORM: begin
        state_nxt = DONE;
        zero_nxt  = 1'b0;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (exp_p0 == 9'd255) begin
          res_nxt = sat_inf(sign_p0);
          ovf_nxt = 1'b1;
        end else if (mant_p0 == 25'h0) begin
          res_nxt  = flush_zero(sign_p0);
          zero_nxt = 1'b1;
        end else if (mant_p0[24]) begin
          if (exp_inc == 9'd255) begin
            res_nxt = sat_inf(sign_p0);
            ovf_nxt = 1'b1;
          end else begin
            res_nxt = {sign_p0, exp_inc[7:0], mant_p0[23:1]};
          end
        end else if (mant_p0[23]) begin
          res_nxt = {sign_p0, exp_p0[7:0], mant_p0[22:0]};
        end else if (exp_p0 <= 9'd1) begin
          // no denormals: anything that cannot reach the hidden bit flushes
          res_nxt = flush_zero(sign_p0);
          unf_nxt = 1'b1;
        end else begin
          mant_nxt  = mant_p0 << 1;
          exp_nxt   = exp_p0 - 9'd1;
          state_nxt = NORM;
        end
      end
      DONE: begin
        if (vld_p1 && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs read as zero whenever no result is presented, including straight out of reset
  assign in_ready   = (state == IDLE);
  assign out_valid  = vld_p1;
  assign out_result = vld_p1 ? res_p1 : 32'h0;
  assign out_zero   = vld_p1 & zero_p1;
  assign out_ovf    = vld_p1 & ovf_p1;
  assign out_unf    = vld_p1 & unf_p1;

endmodule
